// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, I-cache request/hit handshake, IF/ID latch.
// Optional halt-on-opcode-0x3F support is enabled by defining FETCH_HALT_EN.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pc_en,
  input  logic        stall_ifid,
  input  logic        flush_ifid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        halted
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_e;
`else
  typedef enum logic [0:0] {
    RUN,
    DRAIN
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic [31:0] pc_plus4;
  logic        is_run;
  logic        accept;

  assign pc_plus4 = pc_q + 32'd4;
  assign is_run   = (state_q == RUN);
  assign accept   = is_run & ihit & pc_en & ~stall_ifid
                  & ~flush_ifid & ~redirect;

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;
  logic halt_op;

  assign halt_op = (imemload[31:26] == 6'h3F);
  assign imemREN = ~RST & (state_q != HALTED);
  assign halted  = halted_q;
`else
  assign imemREN = ~RST;
  assign halted  = 1'b0;
`endif

  assign imemaddr   = pc_q;
  assign ifid_valid = valid_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = ipc_q;
  assign ifid_pc4   = ipc4_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
`ifdef FETCH_HALT_EN
    halted_d = halted_q;
`endif
    unique case (state_q)
      RUN: begin
        if (redirect && ihit) begin
          pc_d = redirect_pc;
        end else if (redirect) begin
          pend_d  = redirect_pc;
          state_d = DRAIN;
        end else if (accept) begin
`ifdef FETCH_HALT_EN
          if (halt_op) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_plus4;
          end
`else
          pc_d = pc_plus4;
`endif
        end
      end
      DRAIN: begin
        // the in-flight word lands first; only then is the target requested
        if (redirect) pend_d = redirect_pc;
        if (ihit) begin
          pc_d    = redirect ? redirect_pc : pend_q;
          state_d = RUN;
        end
      end
`ifdef FETCH_HALT_EN
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
`endif
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    instr_d = 32'h0;
    ipc_d   = 32'h0;
    ipc4_d  = 32'h0;
    if (flush_ifid) begin
      valid_d = 1'b0;
    end else if (stall_ifid) begin
      valid_d = valid_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      ipc4_d  = ipc4_q;
    end else if (accept) begin
      valid_d = 1'b1;
      instr_d = imemload;
      ipc_d   = pc_q;
      ipc4_d  = pc_plus4;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= PC_RESET;
      pend_q  <= 32'h0;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      ipc4_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed vectors, monitor on negedge.
// Halt checks follow FETCH_HALT_EN when defined.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pc_en, stall_ifid, flush_ifid, redirect, ihit;
  logic [31:0] redirect_pc, imemload;
  logic        imemREN, ifid_valid, halted;
  logic [31:0] imemaddr, ifid_instr, ifid_pc, ifid_pc4;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_word = 32'h0;

  always #5 CLK = ~CLK;

  assign imemload = ovr_en ? ovr_word : (imemaddr ^ 32'h1300_0000);

  fetch_stage dut (
    .CLK(CLK), .RST(RST), .pc_en(pc_en), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .redirect(redirect),
    .redirect_pc(redirect_pc), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .halted(halted)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic        ren;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        halt;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   cyc = 0;
  int   npass = 0;
  int   ntot = 0;

  always @(posedge CLK) cyc++;

  function automatic logic [31:0] pat(input logic [31:0] p);
    return p ^ 32'h1300_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      me = sb.pop_front();
      chk("imemaddr", imemaddr, me.addr);
      chk("imemREN", {31'h0, imemREN}, {31'h0, me.ren});
      chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, me.v});
      chk("ifid_instr", ifid_instr, me.instr);
      chk("ifid_pc", ifid_pc, me.pc);
      chk("ifid_pc4", ifid_pc4, me.pc4);
      chk("halted", {31'h0, halted}, {31'h0, me.halt});
    end
  end

  task automatic step(input logic en, input logic st, input logic fl,
                      input logic rd, input logic [31:0] rpc,
                      input logic hit, input logic [31:0] ea,
                      input logic ev, input logic [31:0] epc,
                      input logic [31:0] ei, input logic eh,
                      input logic er);
    exp_t x;
    @(posedge CLK);
    #1;
    pc_en = en; stall_ifid = st; flush_ifid = fl;
    redirect = rd; redirect_pc = rpc; ihit = hit;
    x.due = cyc + 1;
    x.addr = ea; x.ren = er; x.v = ev; x.instr = ei;
    x.pc = epc; x.pc4 = ev ? epc + 32'd4 : 32'h0; x.halt = eh;
    sb.push_back(x);
  endtask

  task automatic s(input logic en, input logic st, input logic fl,
                   input logic rd, input logic [31:0] rpc,
                   input logic hit, input logic [31:0] ea,
                   input logic ev, input logic [31:0] epc);
    step(en, st, fl, rd, rpc, hit, ea, ev, epc,
         ev ? pat(epc) : 32'h0, 1'b0, 1'b1);
  endtask

  task automatic drain_sb();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("sb_drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic idle();
    pc_en = 1'b0; stall_ifid = 1'b0; flush_ifid = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; ihit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    idle();
    repeat (3) @(negedge CLK);
    chk("rst_ren", {31'h0, imemREN}, 32'h0);
    chk("rst_addr", imemaddr, 32'h0);
    chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc", ifid_pc, 32'h0);
    chk("rst_pc4", ifid_pc4, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    RST = 1'b0;
    #1;
    chk("rel_ren", {31'h0, imemREN}, 32'h1);
    chk("rel_addr", imemaddr, 32'h0);

    s(1, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0);
    s(1, 0, 0, 0, 0, 1, 32'h8, 1, 32'h4);
    s(1, 1, 0, 0, 0, 1, 32'h8, 1, 32'h4);
    s(1, 1, 0, 0, 0, 1, 32'h8, 1, 32'h4);
    s(1, 0, 0, 0, 0, 1, 32'hC, 1, 32'h8);
    s(1, 0, 0, 1, 32'h40, 1, 32'h40, 0, 32'h0);
    s(1, 0, 0, 0, 0, 1, 32'h44, 1, 32'h40);
    s(1, 0, 0, 1, 32'h10, 1, 32'h10, 0, 32'h0);
    s(1, 0, 0, 1, 32'h80, 0, 32'h10, 0, 32'h0);
    s(1, 0, 0, 1, 32'h90, 0, 32'h10, 0, 32'h0);
    s(1, 0, 0, 0, 0, 1, 32'h90, 0, 32'h0);
    s(1, 0, 0, 0, 0, 1, 32'h94, 1, 32'h90);
    s(1, 1, 1, 0, 0, 1, 32'h94, 0, 32'h0);
    s(1, 0, 0, 0, 0, 0, 32'h94, 0, 32'h0);
    s(0, 0, 0, 0, 0, 1, 32'h94, 0, 32'h0);
    s(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0);
    s(1, 0, 0, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC);
    s(1, 0, 1, 0, 0, 1, 32'h0, 0, 32'h0);
    s(1, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0);
    s(1, 0, 0, 1, 32'h100, 0, 32'h4, 0, 32'h0);
    s(1, 0, 0, 1, 32'h200, 1, 32'h200, 0, 32'h0);
    s(1, 0, 0, 0, 0, 1, 32'h204, 1, 32'h200);
    s(1, 0, 0, 1, 32'h300, 0, 32'h204, 0, 32'h0);
    s(1, 0, 0, 0, 0, 0, 32'h204, 0, 32'h0);
    drain_sb();

    RST = 1'b1;
    #1;
    chk("mid_rst_addr", imemaddr, 32'h0);
    chk("mid_rst_ren", {31'h0, imemREN}, 32'h0);
    chk("mid_rst_valid", {31'h0, ifid_valid}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("mid_rel_addr", imemaddr, 32'h0);
    chk("mid_rel_ren", {31'h0, imemREN}, 32'h1);

    s(1, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0);
    s(1, 0, 0, 1, 32'h20, 1, 32'h20, 0, 32'h0);
    drain_sb();
    ovr_en = 1'b1;
    ovr_word = 32'hFC00_0000;
`ifdef FETCH_HALT_EN
    step(1, 0, 0, 0, 0, 1, 32'h20, 1, 32'h20, 32'hFC00_0000, 1, 0);
    step(1, 0, 0, 1, 32'h40, 1, 32'h20, 0, 32'h0, 32'h0, 1, 0);
    drain_sb();
    RST = 1'b1;
    #1;
    chk("halt_rst_addr", imemaddr, 32'h0);
    chk("halt_rst_halted", {31'h0, halted}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("halt_rel_ren", {31'h0, imemREN}, 32'h1);
`else
    step(1, 0, 0, 0, 0, 1, 32'h24, 1, 32'h20, 32'hFC00_0000, 0, 1);
    drain_sb();
`endif
    idle();
    ovr_en = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
